// File: rtl/program_loader_control.sv
// program_loader_control
//   Sequencer between the UART receiver and the instruction memory / pipeline.
//   Decodes single-byte commands ('L' load, 'C' continuous run, 'S' step run),
//   streams program bytes into the instruction memory write port, gates the
//   pipeline clock-enable, and stops execution on the program-end flag.
//   Every output is registered.
//
// Ports
//   i_clock             system clock, rising edge
//   i_reset             asynchronous, active-low reset
//   i_rx_data           received byte
//   i_rx_valid          one-cycle strobe qualifying i_rx_data
//   i_program_end       end-of-program flag from instruction memory
//   o_imem_write_data   byte to instruction memory (holds when not strobed)
//   o_imem_write_enable one-cycle write strobe per program byte
//   o_imem_clear        one-cycle pulse clearing instruction memory
//   o_cpu_reset         one-cycle pulse restarting the PC before a run
//   o_cpu_enable        pipeline advance enable
//   o_program_loaded    a complete program is resident
//   o_done              high while in DONE
//   o_error             one-cycle pulse on protocol error or load timeout
//   o_state             current state encoding (debug)
module program_loader_control #(
  parameter int NB_BYTE        = 8,
  parameter int N_INSTRUCTIONS = 32,
  parameter int NB_COUNT       = 8,
  parameter int LOAD_TIMEOUT   = 1000000,
  parameter int NB_TIMEOUT     = 20
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_program_end,
  output logic [NB_BYTE-1:0] o_imem_write_data,
  output logic               o_imem_write_enable,
  output logic               o_imem_clear,
  output logic               o_cpu_reset,
  output logic               o_cpu_enable,
  output logic               o_program_loaded,
  output logic               o_done,
  output logic               o_error,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_COUNT = 3'd1,
    LOAD_DATA  = 3'd2,
    RUN_CONT   = 3'd3,
    RUN_STEP   = 3'd4,
    DONE       = 3'd5
  } state_t;

  localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'('h4C);
  localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'('h43);
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'('h53);
  localparam logic [NB_BYTE-1:0] CMD_NEXT = NB_BYTE'('h4E);

  state_t                state, state_next;
  logic [NB_COUNT-1:0]   byte_count, byte_count_next;
  logic [NB_TIMEOUT-1:0] idle_count, idle_count_next;
  logic [NB_BYTE-1:0]    write_data_next;
  logic                  write_enable_next;
  logic                  clear_next;
  logic                  cpu_reset_next;
  logic                  cpu_enable_next;
  logic                  loaded_next;
  logic                  error_next;

  logic [NB_BYTE+1:0]    load_bytes;
  logic                  count_ok;
  logic                  run_exit;

  // Four bytes per instruction.
  assign load_bytes = {i_rx_data, 2'b00};
  assign count_ok   = (i_rx_data != '0) &&
                      (i_rx_data <= NB_BYTE'(N_INSTRUCTIONS));
  // The program-end flag is stale while the PC restart pulse is out.
  assign run_exit   = i_program_end && !o_cpu_reset;

  assign o_state = state;

  always_comb begin
    state_next        = state;
    byte_count_next   = byte_count;
    idle_count_next   = '0;
    write_data_next   = o_imem_write_data;
    write_enable_next = 1'b0;
    clear_next        = 1'b0;
    cpu_reset_next    = 1'b0;
    cpu_enable_next   = 1'b0;
    loaded_next       = o_program_loaded;
    error_next        = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            state_next  = LOAD_COUNT;
            clear_next  = 1'b1;
            loaded_next = 1'b0;
          end else if (i_rx_data == CMD_CONT || i_rx_data == CMD_STEP) begin
            if (!o_program_loaded) begin
              error_next = 1'b1;
            end else begin
              cpu_reset_next = 1'b1;
              state_next     = (i_rx_data == CMD_CONT) ? RUN_CONT : RUN_STEP;
            end
          end
        end
      end

      LOAD_COUNT, LOAD_DATA: begin
        // A valid byte always takes priority over an expiring timeout.
        if (!i_rx_valid) begin
          if (idle_count == NB_TIMEOUT'(LOAD_TIMEOUT - 1)) begin
            error_next      = 1'b1;
            state_next      = IDLE;
            byte_count_next = '0;
          end else begin
            idle_count_next = idle_count + NB_TIMEOUT'(1);
          end
        end else if (state == LOAD_COUNT) begin
          if (count_ok) begin
            byte_count_next = NB_COUNT'(load_bytes);
            state_next      = LOAD_DATA;
          end else begin
            error_next = 1'b1;
            state_next = IDLE;
          end
        end else begin
          write_enable_next = 1'b1;
          write_data_next   = i_rx_data;
          byte_count_next   = byte_count - NB_COUNT'(1);
          if (byte_count == NB_COUNT'(1)) begin
            loaded_next = 1'b1;
            state_next  = IDLE;
          end
        end
      end

      RUN_CONT: begin
        if (run_exit) state_next      = DONE;
        else          cpu_enable_next = 1'b1;
      end

      RUN_STEP: begin
        if (run_exit)                                   state_next      = DONE;
        else if (i_rx_valid && i_rx_data == CMD_NEXT)   cpu_enable_next = 1'b1;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state               <= IDLE;
      byte_count          <= '0;
      idle_count          <= '0;
      o_imem_write_data   <= '0;
      o_imem_write_enable <= 1'b0;
      o_imem_clear        <= 1'b0;
      o_cpu_reset         <= 1'b0;
      o_cpu_enable        <= 1'b0;
      o_program_loaded    <= 1'b0;
      o_done              <= 1'b0;
      o_error             <= 1'b0;
    end else begin
      state               <= state_next;
      byte_count          <= byte_count_next;
      idle_count          <= idle_count_next;
      o_imem_write_data   <= write_data_next;
      o_imem_write_enable <= write_enable_next;
      o_imem_clear        <= clear_next;
      o_cpu_reset         <= cpu_reset_next;
      o_cpu_enable        <= cpu_enable_next;
      o_program_loaded    <= loaded_next;
      o_done              <= (state_next == DONE);
      o_error             <= error_next;
    end
  end

endmodule
